// File: rtl/apb_uart_ctrl_if.sv
// APB slave bus bundle for the UART controller.
// The master modport drives requests; the slave modport returns the response.
interface apb_uart_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              psel_i;
    logic              penable_i;
    logic              pwrite_i;
    logic [ADDR_W-1:0] paddr_i;
    logic [31:0]       pwdata_i;
    logic [3:0]        pstrb_i;
    logic [31:0]       prdata_o;
    logic              pready_o;
    logic              pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_uart_ctrl.sv
// APB register front end for the UART: divisor, control, TX FIFO feeding the
// serializer through a valid/ready FSM, and a single-entry RX holding register.
module apb_uart_ctrl #(
    parameter int                ADDR_W     = 12,
    parameter int                FIFO_DEPTH = 8,
    parameter int                DIV_W      = 16,
    parameter logic [DIV_W-1:0]  DIV_RESET  = 16'd868
) (
    input  logic             clk_i,
    input  logic             rst_i,
    apb_uart_ctrl_if.slave   apb,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    output logic [DIV_W-1:0] baud_div_o,
    output logic             tx_en_o,
    output logic             irq_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_DIV    = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    tx_state_e        state_q;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic             tx_en_q;
    logic             tx_en_d;
    logic             ie_tx_empty_q;
    logic             ie_tx_empty_d;
    logic             ie_rx_q;
    logic             ie_rx_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [7:0]       rx_byte_q;
    logic             rx_valid_q;
    logic             rx_overrun_q;
    logic             irq_q;

    logic             access_s;
    logic             addr_ok_s;
    logic [1:0]       reg_sel_s;
    logic             wr_s;
    logic             rd_s;
    logic             tx_full_s;
    logic             tx_empty_s;
    logic             push_s;
    logic             pop_s;
    logic             data_rd_s;
    logic             ovr_clr_s;
    logic [31:0]      rdata_s;
    logic             slverr_s;
    logic [31:0]      cnt32_s;
    logic [31:0]      div32_s;
    logic             unused_bits_s;

    assign access_s   = apb.psel_i & apb.penable_i;
    assign addr_ok_s  = (apb.paddr_i[ADDR_W-1:4] == {(ADDR_W-4){1'b0}});
    assign reg_sel_s  = apb.paddr_i[3:2];
    assign wr_s       = access_s & addr_ok_s & apb.pwrite_i;
    assign rd_s       = access_s & addr_ok_s & ~apb.pwrite_i;
    assign tx_full_s  = (count_q == CNT_FULL);
    assign tx_empty_s = (count_q == {CNT_W{1'b0}});
    assign push_s     = wr_s & (reg_sel_s == A_DATA) & ~tx_full_s;
    assign data_rd_s  = rd_s & (reg_sel_s == A_DATA);
    assign ovr_clr_s  = wr_s & (reg_sel_s == A_STATUS) & apb.pstrb_i[0] & apb.pwdata_i[3];
    // Pops only with tx_en set, so clearing it mid-SEND lets the held byte finish.
    assign pop_s      = tx_en_q & ~tx_empty_s &
                        ((state_q == ST_IDLE) | ((state_q == ST_SEND) & tx_ready_i));
    assign cnt32_s    = 32'(count_q);
    assign div32_s    = 32'(div_q);
    assign unused_bits_s = ^{apb.paddr_i[1:0], apb.pwdata_i, apb.pstrb_i};

    // FIFO level next state
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Control and divisor register next state, byte-strobed
    always_comb begin
        tx_en_d       = tx_en_q;
        ie_tx_empty_d = ie_tx_empty_q;
        ie_rx_d       = ie_rx_q;
        div_d         = div_q;
        if (wr_s && (reg_sel_s == A_CTRL) && apb.pstrb_i[0]) begin
            tx_en_d       = apb.pwdata_i[0];
            ie_tx_empty_d = apb.pwdata_i[1];
            ie_rx_d       = apb.pwdata_i[2];
        end else begin
            tx_en_d       = tx_en_q;
            ie_tx_empty_d = ie_tx_empty_q;
            ie_rx_d       = ie_rx_q;
        end
        if (wr_s && (reg_sel_s == A_DIV)) begin
            for (int i = 0; i < DIV_W; i++) begin
                if (apb.pstrb_i[i>>3]) begin
                    div_d[i] = apb.pwdata_i[i];
                end else begin
                    div_d[i] = div_q[i];
                end
            end
        end else begin
            div_d = div_q;
        end
    end

    // Read mux and error response, live only during the access phase
    always_comb begin
        rdata_s  = 32'd0;
        slverr_s = 1'b0;
        if (access_s) begin
            slverr_s = ~addr_ok_s | (apb.pwrite_i & (reg_sel_s == A_DATA) & tx_full_s);
        end else begin
            slverr_s = 1'b0;
        end
        if (rd_s) begin
            case (reg_sel_s)
                A_DATA:   rdata_s = rx_valid_q ? {24'd0, rx_byte_q} : 32'd0;
                A_STATUS: rdata_s = {24'd0, cnt32_s[3:0], rx_overrun_q, rx_valid_q,
                                     tx_empty_s, tx_full_s};
                A_CTRL:   rdata_s = {29'd0, ie_rx_q, ie_tx_empty_q, tx_en_q};
                A_DIV:    rdata_s = div32_s;
                default:  rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Configuration registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_en_q       <= 1'b0;
            ie_tx_empty_q <= 1'b0;
            ie_rx_q       <= 1'b0;
            div_q         <= DIV_RESET;
        end else begin
            tx_en_q       <= tx_en_d;
            ie_tx_empty_q <= ie_tx_empty_d;
            ie_rx_q       <= ie_rx_d;
            div_q         <= div_d;
        end
    end

    // TX FIFO storage and pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            count_q <= count_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= apb.pwdata_i[7:0];
                wr_ptr_q        <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // TX handshake FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready_i) begin
                        if (pop_s) begin
                            tx_data_q  <= mem_q[rd_ptr_q];
                            tx_valid_q <= 1'b1;
                        end else begin
                            tx_valid_q <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    // RX holding register; a same-cycle DATA read makes room for the new byte
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_byte_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            if (rx_valid_i && (!rx_valid_q || data_rd_s)) begin
                rx_byte_q  <= rx_data_i;
                rx_valid_q <= 1'b1;
            end else if (data_rd_s) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_valid_i && rx_valid_q && !data_rd_s) begin
                rx_overrun_q <= 1'b1;
            end else if (ovr_clr_s) begin
                rx_overrun_q <= 1'b0;
            end
        end
    end

    // Interrupt register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (ie_tx_empty_q & tx_empty_s & ~tx_valid_q) | (ie_rx_q & rx_valid_q);
        end
    end

    assign apb.prdata_o  = rdata_s;
    assign apb.pslverr_o = slverr_s;
    assign apb.pready_o  = 1'b1;
    assign tx_data_o     = tx_data_q;
    assign tx_valid_o    = tx_valid_q;
    assign baud_div_o    = div_q;
    assign tx_en_o       = tx_en_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Directed bench for apb_uart_ctrl: register map, TX FIFO/FSM, RX path, irq, reset.
module tb_apb_uart_ctrl;
    logic        clk_i;
    logic        rst_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [15:0] baud_div_o;
    logic        tx_en_o;
    logic        irq_o;

    int checks;
    int errors;

    apb_uart_ctrl_if #(.ADDR_W(12)) bus ();

    apb_uart_ctrl #(
        .ADDR_W(12), .FIFO_DEPTH(8), .DIV_W(16), .DIV_RESET(16'd868)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .apb        (bus.slave),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .baud_div_o (baud_div_o),
        .tx_en_o    (tx_en_o),
        .irq_o      (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One APB transfer; returns with time just after the edge that ends the access.
    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output logic rdy);
        @(negedge clk_i);
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = wr;
        bus.paddr_i   = addr;
        bus.pwdata_i  = data;
        bus.pstrb_i   = strb;
        @(negedge clk_i);
        bus.penable_i = 1'b1;
        #1;
        rdata = bus.prdata_o;
        err   = bus.pslverr_o;
        rdy   = bus.pready_o;
        @(posedge clk_i);
        #1;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        ry;
        checks = 0;
        errors = 0;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        bus.paddr_i = 12'h0; bus.pwdata_i = 32'h0; bus.pstrb_i = 4'h0;
        tx_ready_i = 1'b0; rx_data_i = 8'h00; rx_valid_i = 1'b0;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
        check("rst_baud", {16'd0, baud_div_o}, 32'd868);
        check("rst_tx_en", {31'd0, tx_en_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_pready", {31'd0, bus.pready_o}, 32'd1);
        check("rst_prdata_idle", bus.prdata_o, 32'd0);
        check("rst_pslverr_idle", {31'd0, bus.pslverr_o}, 32'd0);

        apb_xfer(1'b0, 12'h0, 32'h0, 4'h0, rd, er, ry);
        check("rd_data", rd, 32'h0); check("rd_data_err", {31'd0, er}, 32'd0);
        check("rd_data_rdy", {31'd0, ry}, 32'd1);
        apb_xfer(1'b0, 12'h4, 32'h0, 4'h0, rd, er, ry);
        check("rd_status", rd, 32'h02); check("rd_status_err", {31'd0, er}, 32'd0);
        apb_xfer(1'b0, 12'h8, 32'h0, 4'h0, rd, er, ry);
        check("rd_ctrl", rd, 32'h0); check("rd_ctrl_err", {31'd0, er}, 32'd0);
        apb_xfer(1'b0, 12'hC, 32'h0, 4'h0, rd, er, ry);
        check("rd_div", rd, 32'd868); check("rd_div_rdy", {31'd0, ry}, 32'd1);

        // Only the low byte of the divisor is strobed in
        apb_xfer(1'b1, 12'hC, 32'h1234, 4'b0001, rd, er, ry);
        check("div_wr_err", {31'd0, er}, 32'd0);
        check("baud_div_o", {16'd0, baud_div_o}, 32'h0334);
        apb_xfer(1'b0, 12'hC, 32'h0, 4'h0, rd, er, ry);
        check("div_strobed", rd, 32'h0334);

        // Fill the FIFO with the transmitter disabled; the ninth push overflows
        for (int i = 0; i < 9; i++) begin
            apb_xfer(1'b1, 12'h0, 32'h41 + i, 4'hF, rd, er, ry);
            check($sformatf("push_err_%0d", i), {31'd0, er}, (i == 8) ? 32'd1 : 32'd0);
        end
        apb_xfer(1'b0, 12'h4, 32'h0, 4'h0, rd, er, ry);
        check("status_full", rd, 32'h81);
        check("no_tx_while_dis", {31'd0, tx_valid_o}, 32'd0);

        tx_ready_i = 1'b1;
        apb_xfer(1'b1, 12'h8, 32'h1, 4'h1, rd, er, ry);
        check("tx_en_o_set", {31'd0, tx_en_o}, 32'd1);
        @(posedge clk_i);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            check($sformatf("burst_valid_%0d", i), {31'd0, tx_valid_o}, 32'd1);
            check($sformatf("burst_data_%0d", i), {24'd0, tx_data_o}, 32'h41 + i);
        end
        @(negedge clk_i);
        check("burst_done_valid", {31'd0, tx_valid_o}, 32'd0);
        apb_xfer(1'b0, 12'h4, 32'h0, 4'h0, rd, er, ry);
        check("status_drained", rd, 32'h02);

        // Single byte held until ready, tx_en cleared mid-SEND
        tx_ready_i = 1'b0;
        apb_xfer(1'b1, 12'h0, 32'h55, 4'hF, rd, er, ry);
        check("b55_valid_n1", {31'd0, tx_valid_o}, 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("b55_valid_n2", {31'd0, tx_valid_o}, 32'd1);
        check("b55_data", {24'd0, tx_data_o}, 32'h55);
        apb_xfer(1'b1, 12'h8, 32'h0, 4'h1, rd, er, ry);
        check("b55_hold_valid", {31'd0, tx_valid_o}, 32'd1);
        check("b55_tx_en_clr", {31'd0, tx_en_o}, 32'd0);
        @(negedge clk_i);
        tx_ready_i = 1'b1;
        @(negedge clk_i);
        tx_ready_i = 1'b0;
        check("b55_done_valid", {31'd0, tx_valid_o}, 32'd0);

        // RX overrun keeps the first byte
        @(negedge clk_i); rx_data_i = 8'hA5; rx_valid_i = 1'b1;
        @(negedge clk_i); rx_valid_i = 1'b0;
        @(negedge clk_i); rx_data_i = 8'h3C; rx_valid_i = 1'b1;
        @(negedge clk_i); rx_valid_i = 1'b0;
        apb_xfer(1'b0, 12'h4, 32'h0, 4'h0, rd, er, ry);
        check("status_ovr", rd, 32'h0E);
        apb_xfer(1'b0, 12'h0, 32'h0, 4'h0, rd, er, ry);
        check("rx_data_a5", rd, 32'hA5);
        apb_xfer(1'b0, 12'h4, 32'h0, 4'h0, rd, er, ry);
        check("status_after_rd", rd, 32'h0A);
        apb_xfer(1'b1, 12'h4, 32'h8, 4'h1, rd, er, ry);
        apb_xfer(1'b0, 12'h4, 32'h0, 4'h0, rd, er, ry);
        check("status_ovr_clr", rd, 32'h02);

        // RX interrupt timing
        apb_xfer(1'b1, 12'h8, 32'h4, 4'h1, rd, er, ry);
        @(negedge clk_i); rx_data_i = 8'h11; rx_valid_i = 1'b1;
        @(negedge clk_i); rx_valid_i = 1'b0;
        check("irq_lag", {31'd0, irq_o}, 32'd0);
        @(negedge clk_i);
        check("irq_rx_set", {31'd0, irq_o}, 32'd1);
        apb_xfer(1'b0, 12'h0, 32'h0, 4'h0, rd, er, ry);
        check("rx_data_11", rd, 32'h11);
        check("irq_rd_edge", {31'd0, irq_o}, 32'd1);
        @(posedge clk_i); #1;
        check("irq_rx_clr", {31'd0, irq_o}, 32'd0);

        apb_xfer(1'b0, 12'h10, 32'h0, 4'h0, rd, er, ry);
        check("unmapped_rd_err", {31'd0, er}, 32'd1);
        check("unmapped_rd_data", rd, 32'd0);
        apb_xfer(1'b1, 12'h10, 32'hFF, 4'hF, rd, er, ry);
        check("unmapped_wr_err", {31'd0, er}, 32'd1);

        // TX-empty interrupt
        apb_xfer(1'b1, 12'h8, 32'h2, 4'h1, rd, er, ry);
        check("irq_txe_lag", {31'd0, irq_o}, 32'd0);
        @(posedge clk_i); #1;
        check("irq_txe_set", {31'd0, irq_o}, 32'd1);

        // Asynchronous reset mid-transfer discards FIFO contents
        apb_xfer(1'b1, 12'h8, 32'h1, 4'h1, rd, er, ry);
        apb_xfer(1'b1, 12'h0, 32'h77, 4'hF, rd, er, ry);
        apb_xfer(1'b1, 12'h0, 32'h78, 4'hF, rd, er, ry);
        check("pre_rst_valid", {31'd0, tx_valid_o}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, tx_valid_o}, 32'd0);
        check("mid_rst_tx_en", {31'd0, tx_en_o}, 32'd0);
        check("mid_rst_baud", {16'd0, baud_div_o}, 32'd868);
        @(negedge clk_i);
        rst_i = 1'b0;
        apb_xfer(1'b0, 12'h4, 32'h0, 4'h0, rd, er, ry);
        check("post_rst_status", rd, 32'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
